// File: rtl/uart_rx_frontend_if.sv
// rtl/uart_rx_frontend_if.sv - received-byte stream and error status bundle for uart_rx_frontend
//
// master: the receiver (drives rx_data/rx_valid, frame_err, overrun, err_count)
// slave : the consumer (drives rx_ready)
interface uart_rx_frontend_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [7:0] err_count;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output frame_err,
        output overrun,
        output err_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  frame_err,
        input  overrun,
        input  err_count
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 8N1 UART receive front end with holding register and error counter
//
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous active-low reset
//   RXD   - asynchronous serial line, idle high
//   rx    - master side of uart_rx_frontend_if: byte stream (rx_data/rx_valid/rx_ready),
//           frame_err and overrun one-cycle pulses, saturating err_count
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               RXD,
    uart_rx_frontend_if.master rx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic                   rxd_s;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sync_q       <= '1;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_q      <= '0;
            rx.rx_data   <= '0;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
            rx.err_count <= '0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], RXD};
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;

            // The two pulses come from mutually exclusive stop-bit outcomes,
            // so one increment per cycle is enough.
            if ((rx.frame_err || rx.overrun) && rx.err_count != 8'hFF) begin
                rx.err_count <= rx.err_count + 8'd1;
            end

            // Consumer handshake; a delivery in the STOP branch below takes
            // precedence because it is assigned later in this block.
            if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift_q <= {rxd_s, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            // Good stop: going straight to IDLE lets a
                            // back-to-back start bit be caught.
                            state <= IDLE;
                            if (!rx.rx_valid || rx.rx_ready) begin
                                rx.rx_data  <= shift_q;
                                rx.rx_valid <= 1'b1;
                            end else begin
                                rx.overrun <= 1'b1;
                            end
                        end else begin
                            // A held-low line (break) must report only once.
                            rx.frame_err <= 1'b1;
                            state        <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - scoreboard bench for uart_rx_frontend
module tb_uart_rx_frontend;
    localparam int CPB = 8;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic RXD   = 1'b1;

    uart_rx_frontend_if ifc ();

    uart_rx_frontend #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .RXD  (RXD),
        .rx   (ifc.master)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int ferr_seen = 0, ovr_seen = 0, valid_cycles = 0, pops = 0;
    int ferr_base = 0, ovr_base = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: inputs change on the falling edge, so sampling just after it
    // sees exactly what the DUT will act on at the next rising edge.
    always @(negedge CLK) begin
        #1;
        if (RESET) begin
            if (ifc.frame_err) ferr_seen++;
            if (ifc.overrun)   ovr_seen++;
            if (ifc.rx_valid)  valid_cycles++;
            if (prev_hold && ifc.rx_valid) check("data_stable", ifc.rx_data, prev_data);
            if (ifc.rx_valid && ifc.rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", ifc.rx_data, 256);
                end else begin
                    check("rx_data", ifc.rx_data, exp_q.pop_front());
                    pops++;
                end
            end
            prev_hold = ifc.rx_valid && !ifc.rx_ready;
            prev_data = ifc.rx_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic send_bit(input logic v);
        RXD = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        RXD = 1'b1;
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        RXD   = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        exp_q.delete();
        exp_ferr  = 0;
        exp_ovr   = 0;
        ferr_base = ferr_seen;
        ovr_base  = ovr_seen;
    endtask

    task automatic check_counts(input string tag);
        int e;
        e = exp_ferr + exp_ovr;
        if (e > 255) e = 255;
        check({tag, "_frame_err_pulses"}, ferr_seen - ferr_base, exp_ferr);
        check({tag, "_overrun_pulses"}, ovr_seen - ovr_base, exp_ovr);
        check({tag, "_err_count"}, ifc.err_count, e);
        check({tag, "_pending_bytes"}, exp_q.size(), 0);
    endtask

    initial begin
        int v0, p0, gap;
        logic [7:0] b;
        logic ok;

        ifc.rx_ready = 1'b0;
        @(negedge CLK);

        // Reset state and quiet line
        do_reset();
        check("reset_rx_valid", ifc.rx_valid, 0);
        check("reset_rx_data", ifc.rx_data, 0);
        check("reset_err_count", ifc.err_count, 0);
        idle(200);
        check("quiet_valid_cycles", valid_cycles, 0);
        check_counts("quiet");

        // Single byte, consumer always ready
        ifc.rx_ready = 1'b1;
        v0 = valid_cycles;
        p0 = pops;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_pops", pops - p0, 1);
        check_counts("a5");

        // Back-to-back with consumer stalled: second byte overruns
        do_reset();
        ifc.rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        exp_ovr++;
        idle(10);
        check("ovr_held_valid", ifc.rx_valid, 1);
        check("ovr_held_data", ifc.rx_data, 8'h3C);
        check("ovr_err_count", ifc.err_count, 1);
        ifc.rx_ready = 1'b1;
        @(negedge CLK);
        #2;
        check("ovr_valid_cleared", ifc.rx_valid, 0);
        check_counts("ovr");

        // Bad stop bit followed by a long break, then a good frame
        do_reset();
        ifc.rx_ready = 1'b1;
        v0 = valid_cycles;
        send_frame(8'h55, 1'b0);
        exp_ferr++;
        RXD = 1'b0;
        repeat (40) @(negedge CLK);
        idle(16);
        check("break_no_valid", valid_cycles - v0, 0);
        check_counts("break");
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        idle(20);
        check_counts("after_break");

        // Start-bit glitch
        do_reset();
        v0 = valid_cycles;
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        idle(30);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check_counts("glitch");
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(20);
        check_counts("after_glitch");

        // Reset in the middle of data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        RXD = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        do_reset();
        v0 = valid_cycles;
        idle(2 * CPB);
        check("abort_no_valid", valid_cycles - v0, 0);
        check_counts("abort");
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(20);
        check("abort_data", ifc.rx_data, 8'h7E);
        check_counts("after_abort");

        // Randomised mix of good and bad frames
        do_reset();
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            if (ok) exp_q.push_back(b);
            else    exp_ferr++;
            send_frame(b, ok);
            gap = ok ? $urandom_range(0, 12) : CPB + $urandom_range(0, 12);
            idle(gap);
        end
        idle(30);
        check_counts("random");

        // Error counter saturation
        do_reset();
        for (int n = 0; n < 300; n++) begin
            send_frame(8'($urandom), 1'b0);
            exp_ferr++;
            idle(CPB);
        end
        idle(10);
        check_counts("saturate");
        check("saturate_ff", ifc.err_count, 255);
        idle(50);
        check("saturate_hold", ifc.err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
